// File: rtl/store_tag_buffer.sv
// In-order store buffer with per-byte producer tags. Pending stores drain to memory
// in FIFO order; loads see the youngest matching byte of every lane combinationally.
module store_tag_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 30,
    parameter int TAG_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_be,
    input  logic [TAG_W-1:0]         st_tag,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic [TAG_W-1:0]         tag1,
    output logic [TAG_W-1:0]         tag2,
    output logic [TAG_W-1:0]         tag3,
    output logic [TAG_W-1:0]         tag4,
    output logic [3:0]               byte_hit,
    output logic [31:0]              ld_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [31:0]              mem_data,
    output logic [3:0]               mem_be,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TAG_W-1:0] NO_TAG = '1;
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];

    logic enq;
    logic deq;

    assign st_ready  = (count_q != FULL) && !flush;
    assign mem_valid = (count_q != '0) && !flush;
    assign enq       = st_valid && st_ready;
    assign deq       = mem_valid && mem_ready;

    assign mem_addr = addr_q[rd_ptr_q];
    assign mem_data = data_q[rd_ptr_q];
    assign mem_be   = be_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = '0;
        end else begin
            // enq and deq never target the same slot: that needs count 0 or DEPTH
            if (enq) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Payload needs no reset: every read of it is qualified by valid/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
            be_q[wr_ptr_q]   <= st_be;
            tag_q[wr_ptr_q]  <= st_tag;
        end
    end

    // Entries ordered oldest (k=0) to youngest, with liveness per age slot.
    logic [PTR_W-1:0] age_idx  [DEPTH];
    logic [DEPTH-1:0] age_live;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi]  = rd_ptr_q + PTR_W'(gi);
            assign age_live[gi] = (CNT_W'(gi) < count_q) && valid_q[age_idx[gi]];
        end
    endgenerate

    logic [TAG_W-1:0] lane_tag [4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic             hit_l;
            logic [TAG_W-1:0] tag_l;
            logic [7:0]       data_l;

            // Oldest-first scan; later matches overwrite, so the youngest store wins.
            always_comb begin
                hit_l  = 1'b0;
                tag_l  = NO_TAG;
                data_l = 8'h00;
                for (int k = 0; k < DEPTH; k++) begin
                    if (age_live[k] && (addr_q[age_idx[k]] == ld_addr) &&
                        be_q[age_idx[k]][gi]) begin
                        hit_l  = 1'b1;
                        tag_l  = tag_q[age_idx[k]];
                        data_l = data_q[age_idx[k]][8*gi +: 8];
                    end
                end
            end

            assign byte_hit[gi]       = hit_l;
            assign ld_data[8*gi +: 8] = data_l;
            assign lane_tag[gi]       = tag_l;
        end
    endgenerate

    assign tag1 = lane_tag[0];
    assign tag2 = lane_tag[1];
    assign tag3 = lane_tag[2];
    assign tag4 = lane_tag[3];

endmodule

// File: tb/tb_store_tag_buffer.sv
// Scoreboard bench for store_tag_buffer: enqueued stores are queued and checked
// against the memory drain, and lookups are checked against the queued contents.
module tb_store_tag_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [29:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_be = '0;
    logic [5:0]  st_tag = '0;
    logic [29:0] ld_addr = '0;
    logic [5:0]  tag1, tag2, tag3, tag4;
    logic [3:0]  byte_hit;
    logic [31:0] ld_data;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [5:0]  tag;
    } ent_t;

    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    store_tag_buffer #(.DEPTH(4), .ADDR_W(30), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_be(st_be), .st_tag(st_tag),
        .ld_addr(ld_addr), .tag1(tag1), .tag2(tag2), .tag3(tag3), .tag4(tag4),
        .byte_hit(byte_hit), .ld_data(ld_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_be(mem_be), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected lookup from the scoreboard: youngest matching store per lane.
    task automatic chk_lookup(input string nm);
        logic [3:0]  eh;
        logic [5:0]  et [4];
        logic [31:0] ed;
        eh = '0;
        ed = '0;
        for (int l = 0; l < 4; l++) et[l] = '1;
        for (int k = 0; k < sb.size(); k++) begin
            for (int l = 0; l < 4; l++) begin
                if (sb[k].addr == ld_addr && sb[k].be[l]) begin
                    eh[l]          = 1'b1;
                    et[l]          = sb[k].tag;
                    ed[8*l +: 8]   = sb[k].data[8*l +: 8];
                end
            end
        end
        chk({nm, "_hit"},  byte_hit, eh);
        chk({nm, "_tag1"}, tag1, et[0]);
        chk({nm, "_tag2"}, tag2, et[1]);
        chk({nm, "_tag3"}, tag3, et[2]);
        chk({nm, "_tag4"}, tag4, et[3]);
        chk({nm, "_data"}, ld_data, ed);
    endtask

    // Records handshakes just before the edge, then returns 1 time unit after it.
    task automatic tick();
        ent_t e;
        #2;
        if (flush) begin
            sb.delete();
            $display("[TB] flush");
        end else begin
            if (mem_valid && mem_ready) begin
                if (sb.size() == 0) begin
                    chk("deq_when_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] deq addr=%h data=%h be=%b", mem_addr, mem_data, mem_be);
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_data", mem_data, e.data);
                    chk("mem_be",   mem_be,   e.be);
                end
            end
            if (st_valid && st_ready) begin
                sb.push_back('{addr: st_addr, data: st_data, be: st_be, tag: st_tag});
                $display("[TB] enq addr=%h data=%h be=%b tag=%0d", st_addr, st_data, st_be, st_tag);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [5:0] t);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = b;
        st_tag   = t;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int guard;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_st_ready", st_ready, 1);
        ld_addr = 30'h10;
        #1;
        chk_lookup("rst");
        chk("rst_tag1", tag1, 6'h3f);

        // Full-word store then younger partial store to the same word
        store(30'h10, 32'hAABBCCDD, 4'b1111, 6'd5);
        #1;
        chk("w1_count", count, 1);
        chk("w1_hit", byte_hit, 4'b1111);
        chk("w1_data", ld_data, 32'hAABBCCDD);
        chk_lookup("w1");
        store(30'h10, 32'h00001122, 4'b0011, 6'd9);
        #1;
        chk("p_tags", {tag1, tag2, tag3, tag4}, {6'd9, 6'd9, 6'd5, 6'd5});
        chk("p_data", ld_data, 32'hAABB1122);
        chk_lookup("p");
        ld_addr = 30'h11;
        #1;
        chk("miss_hit", byte_hit, 4'b0000);
        chk("miss_data", ld_data, 32'h0);
        chk_lookup("miss");

        // Fill, then drain one while the next store is held off
        store(30'h20, 32'h11111111, 4'b0101, 6'd1);
        store(30'h21, 32'h22222222, 4'b1010, 6'd2);
        #1;
        chk("full_count", count, 4);
        chk("full_st_ready", st_ready, 0);
        st_valid = 1'b1; st_addr = 30'h30; st_data = 32'h33333333; st_be = 4'hf; st_tag = 6'd3;
        mem_ready = 1'b1;
        #1;
        chk("full_deq_st_ready", st_ready, 0);
        chk("full_mem_valid", mem_valid, 1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("after_deq_count", count, 3);
        chk("after_deq_st_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        #1;
        chk("held_enq_count", count, 4);
        ld_addr = 30'h30;
        #1;
        chk_lookup("held");
        mem_ready = 1'b1;
        guard = 0;
        while (count != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("drain_count", count, 0);
        chk("drain_sb", sb.size(), 0);

        // Wrap-around with random store stalls and concurrent lookups
        sent  = 0;
        guard = 0;
        while (sent < 10 && guard < 300) begin
            st_valid = ($urandom_range(0, 3) != 0);
            st_addr  = 30'(32'h100 + sent);
            st_data  = $urandom;
            st_be    = 4'($urandom_range(0, 15));
            st_tag   = 6'($urandom_range(0, 62));
            ld_addr  = 30'(32'h100 + $urandom_range(0, 9));
            #1;
            chk_lookup("wrap");
            if (st_valid && st_ready) sent++;
            tick();
            guard++;
        end
        st_valid = 1'b0;
        chk("wrap_sent", sent, 10);
        guard = 0;
        while (count != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("wrap_count", count, 0);
        chk("wrap_sb", sb.size(), 0);

        // Flush with three entries and both handshakes requested
        mem_ready = 1'b0;
        store(30'h40, 32'h44444444, 4'hf, 6'd10);
        store(30'h41, 32'h55555555, 4'hf, 6'd11);
        store(30'h42, 32'h66666666, 4'hf, 6'd12);
        #1;
        chk("pre_flush_count", count, 3);
        flush = 1'b1; st_valid = 1'b1; st_addr = 30'h50; mem_ready = 1'b1; ld_addr = 30'h40;
        #1;
        chk("flush_st_ready", st_ready, 0);
        chk("flush_mem_valid", mem_valid, 0);
        tick();
        flush = 1'b0; st_valid = 1'b0; mem_ready = 1'b0;
        #1;
        chk("post_flush_count", count, 0);
        chk("post_flush_hit", byte_hit, 4'b0000);
        chk_lookup("post_flush");

        // Asynchronous reset mid-cycle with two entries
        store(30'h60, 32'h77777777, 4'hf, 6'd20);
        store(30'h61, 32'h88888888, 4'hf, 6'd21);
        ld_addr = 30'h60;
        #1;
        chk("pre_rst_count", count, 2);
        chk("pre_rst_hit", byte_hit, 4'b1111);
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_mem_valid", mem_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_tags", {tag1, tag2, tag3, tag4}, {4{6'h3f}});
        chk("arst_hit", byte_hit, 4'b0000);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_st_ready", st_ready, 1);
        chk_lookup("arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_tag_buffer.md
Name: store_tag_buffer

Overview:
- In-order store buffer with per-byte producer tags; sits directly upstream of the load tag comparator.
- Holds pending stores until memory accepts them.
- Answers load lookups combinationally with per-byte-lane tags (tag1..tag4), hit flags and forwarded data.
- The comparator decides the byte/half/word match from these outputs; memory drains in FIFO order over a valid/ready handshake.

Parameters:
DEPTH, 4, number of entries (power of two, >=2)
ADDR_W, 30, word address width
TAG_W, 6, producer tag width; all-ones value reserved as "no tag"

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries
st_valid  in  1  store request valid
st_ready  out  1  buffer can accept store
st_addr  in  ADDR_W  store word address
st_data  in  32  store data, lane i = bits 8i+7:8i
st_be  in  4  store byte enables
st_tag  in  TAG_W  producer tag of store
ld_addr  in  ADDR_W  load lookup word address
tag1  out  TAG_W  tag for lane 0
tag2  out  TAG_W  tag for lane 1
tag3  out  TAG_W  tag for lane 2
tag4  out  TAG_W  tag for lane 3
byte_hit  out  4  per-lane forward hit
ld_data  out  32  forwarded bytes (0 on missed lanes)
mem_valid  out  1  head entry valid toward memory
mem_ready  in  1  memory accepts head
mem_addr  out  ADDR_W  head address
mem_data  out  32  head data
mem_be  out  4  head byte enables
count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- One clock domain (clk). rst_n is asynchronous, active-low.
- Reset (rst_n=0, async):
  - wr_ptr, rd_ptr and count are 0; all entry valid bits are 0.
  - Outputs: mem_valid=0, byte_hit=0, tag1..tag4 all-ones, ld_data=0, st_ready=1 after release.
  - Reset mid-transfer discards all entries; no partial state survives.
- Circular FIFO:
  - Entry = {addr, data, be, tag}.
  - Pointers are clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
  - count is a separate register, range 0..DEPTH.
- st_ready = (count != DEPTH) && !flush, combinational.
- Enqueue when st_valid && st_ready:
  - Entry written at wr_ptr on the rising edge; wr_ptr+1.
  - st_be=0 is still enqueued and drained.
- mem_valid = (count != 0) && !flush.
  - mem_addr/data/be come from the rd_ptr entry; head fields are don't-care when mem_valid=0.
  - Dequeue when mem_valid && mem_ready; rd_ptr+1.
- Simultaneous enqueue and dequeue: count unchanged.
  - When full, dequeue this cycle does NOT raise st_ready in the same cycle; the freed slot is usable next cycle.
- flush=1:
  - On the next edge, all entries are invalidated and pointers and count go to 0.
  - Flush has priority over enqueue and dequeue that cycle; neither handshake can complete because st_ready=0 and mem_valid=0.
- Lookup (zero latency, combinational from registered state only). For each lane i:
  - Scan entries youngest to oldest: wr_ptr-1 back to rd_ptr, modulo DEPTH, over count entries.
  - The first entry with addr==ld_addr and be[i]=1 sets byte_hit[i]=1, tag(i+1)=entry.tag and ld_data lane i = entry data lane i.
  - Otherwise byte_hit[i]=0, tag=all-ones, ld_data lane i = 0.
  - Lanes are resolved independently, so different lanes may come from different stores.
  - A store enqueued this cycle is not visible until the next cycle.
  - An entry dequeued this cycle remains visible this cycle.
- The upstream producer never issues st_tag = all-ones; behaviour is undefined if it does.
- Full (count==DEPTH) and empty (count==0) are distinguished by count alone, not by pointer equality.

Test Plan:
- Reset, then enqueue {addr=0x10, data=0xAABBCCDD, be=4'b1111, tag=5} with mem_ready=0; next cycle ld_addr=0x10 -> byte_hit=4'b1111, tag1..4=5, ld_data=0xAABBCCDD, count=1.
- Younger partial store: add {addr=0x10, data=0x00001122, be=4'b0011, tag=9} -> tag1=9, tag2=9, tag3=5, tag4=5, ld_data=0xAABB1122; ld_addr=0x11 -> byte_hit=0, tags all-ones, ld_data=0.
- Fill: 4 stores with mem_ready=0 -> count=4, st_ready=0; next store held off. Raise mem_ready for one cycle while st_valid=1 -> head drains, count=3, st_ready=1 next cycle; the held store enqueues.
- Wrap-around: 10 stores with mem_ready always 1 and random stalls -> mem_addr sequence equals enqueue order and count returns to 0.
- Flush with count=3, st_valid=1, mem_ready=1 -> st_ready=0 and mem_valid=0 that cycle; next cycle count=0 and lookup misses.
- Assert rst_n=0 asynchronously mid-cycle with count=2 -> mem_valid drops immediately, count=0, tags all-ones.
